// File: rtl/wb_port_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Holds the long-latency buffer entry layout and the write source select.
package wb_port_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_DATA_W-1:0] wdata;
    } lq_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_LQ
    } wb_src_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Long-latency result buffer: small FIFO of {waddr,wdata} entries with
// wrapping pointers and an occupancy count. No same-cycle flow-through.
module wb_lq_fifo
    import wb_port_arb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  lq_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output lq_entry_t head
);

    localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

    lq_entry_t         r_mem [LQ_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == CNT_W'(LQ_DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arb.sv
// Owns the single register-file write port: merges in-order pipeline
// writeback with buffered long-latency results and tracks pending registers.
module wb_port_arb
    import wb_port_arb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wen,
    input  logic [REG_ADDR_W-1:0] pipe_waddr,
    input  logic [REG_DATA_W-1:0] pipe_wdata,
    output logic                  pipe_hold,
    input  logic                  lu_issue,
    input  logic [REG_ADDR_W-1:0] lu_issue_waddr,
    output logic                  issue_conflict,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_waddr,
    input  logic [REG_DATA_W-1:0] lu_wdata,
    output logic                  lu_ready,
    input  logic                  ren1,
    input  logic                  ren2,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  read_stall,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_DATA_W-1:0] wdata
);

    localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

    logic        w_full;
    logic        w_empty;
    lq_entry_t   w_head;
    lq_entry_t   w_push_entry;
    logic        w_push;
    logic        w_pop;
    logic        w_lq_write;
    logic        w_pipe_real;
    logic        w_hold_act;
    logic        w_stall1;
    logic        w_stall2;
    wb_src_e     w_src;

    logic [ST_W-1:0] r_starve;
    logic [ST_W-1:0] w_starve_nxt;
    logic            r_hold;
    logic [31:0]     r_pending;
    logic [31:0]     w_pending_nxt;

    assign w_push_entry = '{waddr: lu_waddr, wdata: lu_wdata};
    assign w_push       = lu_valid && !w_full && !rst;

    wb_lq_fifo #(
        .LQ_DEPTH(LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_entry(w_push_entry),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign w_pipe_real = pipe_wen && (pipe_waddr != ZERO_REG);
    assign w_hold_act  = r_hold && !w_empty;

    always_comb begin
        w_src = SRC_NONE;
        if (!rst) begin
            if (w_hold_act) begin
                w_src = SRC_LQ;
            end else if (w_pipe_real) begin
                w_src = SRC_PIPE;
            end else if (!w_empty) begin
                w_src = SRC_LQ;
            end
        end
    end

    // A popped r0 result is discarded: it frees the buffer slot but never writes.
    assign w_pop      = (w_src == SRC_LQ);
    assign w_lq_write = w_pop && (w_head.waddr != ZERO_REG);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (w_src)
            SRC_PIPE: begin
                we    = 1'b1;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end
            SRC_LQ: begin
                we    = w_lq_write;
                waddr = w_head.waddr;
                wdata = w_head.wdata;
            end
            default: begin
                we    = 1'b0;
            end
        endcase
    end

    assign lu_ready  = rst || !w_full;
    assign pipe_hold = !rst && w_hold_act;

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve != ST_W'(STARVE_MAX)) begin
            w_starve_nxt = r_starve + ST_W'(1);
        end
    end

    // Clear before set so an issue in the same cycle as the retiring pop wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_lq_write) begin
            w_pending_nxt[w_head.waddr] = 1'b0;
        end
        if (lu_issue && (lu_issue_waddr != ZERO_REG)) begin
            w_pending_nxt[lu_issue_waddr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve  <= '0;
            r_hold    <= 1'b0;
            r_pending <= '0;
        end else begin
            r_starve  <= w_starve_nxt;
            r_hold    <= (w_starve_nxt == ST_W'(STARVE_MAX));
            r_pending <= w_pending_nxt;
        end
    end

    assign w_stall1 = ren1 && (raddr1 != ZERO_REG) && r_pending[raddr1]
                      && !(w_lq_write && (w_head.waddr == raddr1));
    assign w_stall2 = ren2 && (raddr2 != ZERO_REG) && r_pending[raddr2]
                      && !(w_lq_write && (w_head.waddr == raddr2));

    assign read_stall     = !rst && (w_stall1 || w_stall2);
    assign issue_conflict = !rst && lu_issue && (lu_issue_waddr != ZERO_REG)
                            && r_pending[lu_issue_waddr];

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb (LQ_DEPTH=2, STARVE_MAX=4) with
// hand-computed expectations checked by immediate assertions.
module tb_wb_port_arb;

    logic        clk;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_hold;
    logic        lu_issue;
    logic [4:0]  lu_issue_waddr;
    logic        issue_conflict;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        ren1;
    logic        ren2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        read_stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_cmp;
    int n_err;

    wb_port_arb #(
        .LQ_DEPTH  (2),
        .STARVE_MAX(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wen      (pipe_wen),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .pipe_hold     (pipe_hold),
        .lu_issue      (lu_issue),
        .lu_issue_waddr(lu_issue_waddr),
        .issue_conflict(issue_conflict),
        .lu_valid      (lu_valid),
        .lu_waddr      (lu_waddr),
        .lu_wdata      (lu_wdata),
        .lu_ready      (lu_ready),
        .ren1          (ren1),
        .ren2          (ren2),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .read_stall    (read_stall),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lu_issue = 1'b0; lu_issue_waddr = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        ren1 = 1'b0; ren2 = 1'b0; raddr1 = '0; raddr2 = '0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_wen = 1'b1; pipe_waddr = a; pipe_wdata = d;
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid = 1'b1; lu_waddr = a; lu_wdata = d;
    endtask

    task automatic issue(input logic [4:0] a);
        lu_issue = 1'b1; lu_issue_waddr = a;
    endtask

    task automatic rd1(input logic [4:0] a);
        ren1 = 1'b1; raddr1 = a;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        idle();
        step();

        // Outputs while reset is held, with traffic on every input
        pipe(5'd5, 32'h1111_1111); issue(5'd8); rd1(5'd8); lu(5'd2, 32'h22);
        #1;
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_hold", pipe_hold, 0);
        chk("rst_read_stall", read_stall, 0);
        chk("rst_issue_conflict", issue_conflict, 0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_we", we, 0);
        chk("post_rst_lu_ready", lu_ready, 1);

        // Pipeline-only writes
        pipe(5'd5, 32'h1234_5678);
        #1;
        chk("pipe_we", we, 1);
        chk("pipe_waddr", waddr, 5);
        chk("pipe_wdata", wdata, 32'h1234_5678);
        step();
        pipe(5'd0, 32'hFFFF_FFFF);
        #1;
        chk("pipe_r0_we", we, 0);
        step();
        idle();

        // Scoreboard: issue r8, stall, result, release
        issue(5'd8);
        #1;
        chk("sb_issue_no_conflict", issue_conflict, 0);
        step();
        idle(); rd1(5'd8); issue(5'd8);
        #1;
        chk("sb_read_stall_set", read_stall, 1);
        chk("sb_second_issue_conflict", issue_conflict, 1);
        step();
        idle(); ren2 = 1'b1; raddr2 = 5'd8;
        #1;
        chk("sb_read_stall_port2", read_stall, 1);
        step();
        idle(); lu(5'd8, 32'h0000_CAFE);
        #1;
        chk("sb_push_ready", lu_ready, 1);
        chk("sb_no_flow_through", we, 0);
        step();
        idle(); rd1(5'd8);
        #1;
        chk("sb_pop_we", we, 1);
        chk("sb_pop_waddr", waddr, 8);
        chk("sb_pop_wdata", wdata, 32'h0000_CAFE);
        chk("sb_bypass_no_stall", read_stall, 0);
        step();
        idle(); rd1(5'd8);
        #1;
        chk("sb_cleared", read_stall, 0);
        chk("sb_empty_we", we, 0);
        step();

        // Issue to r0 sets nothing
        idle(); issue(5'd0);
        #1;
        chk("r0_issue_conflict", issue_conflict, 0);
        step();
        idle(); issue(5'd0);
        #1;
        chk("r0_issue_again", issue_conflict, 0);
        step();

        // Result to r0 is popped silently; the next result follows right behind
        idle(); lu(5'd0, 32'hDEAD);
        step();
        idle(); lu(5'd7, 32'h77);
        #1;
        chk("r0_pop_we", we, 0);
        step();
        idle();
        #1;
        chk("r7_after_r0_we", we, 1);
        chk("r7_after_r0_waddr", waddr, 7);
        chk("r7_after_r0_wdata", wdata, 32'h77);
        step();

        // Same-cycle issue and pop of r8: pending remains set
        idle(); issue(5'd8);
        step();
        idle(); lu(5'd8, 32'h88);
        step();
        idle(); issue(5'd8); rd1(5'd8);
        #1;
        chk("same_pop_waddr", waddr, 8);
        chk("same_pop_wdata", wdata, 32'h88);
        chk("same_issue_conflict", issue_conflict, 1);
        chk("same_bypass", read_stall, 0);
        step();
        idle(); rd1(5'd8);
        #1;
        chk("same_set_wins", read_stall, 1);
        step();
        idle(); lu(5'd8, 32'h89);
        step();
        idle();
        #1;
        chk("r8_retire_waddr", waddr, 8);
        chk("r8_retire_wdata", wdata, 32'h89);
        step();
        idle(); rd1(5'd8);
        #1;
        chk("r8_retired", read_stall, 0);
        step();

        // Starvation: pipeline owns the port until pipe_hold forces the buffer out
        idle(); pipe(5'd4, 32'h40); lu(5'd3, 32'h33);
        #1;
        chk("starve_t0_waddr", waddr, 4);
        chk("starve_t0_ready", lu_ready, 1);
        step();
        idle(); pipe(5'd4, 32'h40);
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("starve_pipe_waddr", waddr, 4);
            chk("starve_no_hold", pipe_hold, 0);
            step();
        end
        #1;
        chk("starve_t5_hold", pipe_hold, 1);
        chk("starve_t5_we", we, 1);
        chk("starve_t5_waddr", waddr, 3);
        chk("starve_t5_wdata", wdata, 32'h33);
        step();
        #1;
        chk("starve_t6_hold", pipe_hold, 0);
        chk("starve_t6_waddr", waddr, 4);
        step();

        // Full buffer under continuous pipeline traffic; order preserved
        idle(); pipe(5'd4, 32'h40); lu(5'd10, 32'hA0);
        step();
        lu(5'd11, 32'hA1);
        #1;
        chk("full_second_ready", lu_ready, 1);
        step();
        lu(5'd12, 32'hA2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_not_ready", lu_ready, 0);
            chk("full_pipe_waddr", waddr, 4);
            step();
        end
        #1;
        chk("full_hold", pipe_hold, 1);
        chk("full_pop_waddr", waddr, 10);
        chk("full_pop_wdata", wdata, 32'hA0);
        chk("full_ready_during_pop", lu_ready, 0);
        step();
        #1;
        chk("full_third_ready", lu_ready, 1);
        chk("full_hold_clear", pipe_hold, 0);
        chk("full_pipe_again", waddr, 4);
        step();
        lu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full2_not_ready", lu_ready, 0);
            chk("full2_pipe_waddr", waddr, 4);
            step();
        end
        #1;
        chk("full2_hold", pipe_hold, 1);
        chk("full2_pop_waddr", waddr, 11);
        chk("full2_pop_wdata", wdata, 32'hA1);
        step();
        idle();
        #1;
        chk("full3_hold", pipe_hold, 0);
        chk("full3_pop_waddr", waddr, 12);
        chk("full3_pop_wdata", wdata, 32'hA2);
        step();
        #1;
        chk("full_drained_we", we, 0);
        step();

        // Reset mid-operation drops buffered results and pending bits
        idle(); issue(5'd8);
        step();
        idle(); pipe(5'd4, 32'h40); lu(5'd8, 32'hB8);
        step();
        lu(5'd9, 32'hB9);
        step();
        lu_valid = 1'b0; rd1(5'd8);
        #1;
        chk("mid_full", lu_ready, 0);
        chk("mid_stall_before_rst", read_stall, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", lu_ready, 1);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_stall", read_stall, 0);
        step();
        rst = 1'b0;
        idle(); rd1(5'd8);
        #1;
        chk("after_rst_ready", lu_ready, 1);
        chk("after_rst_stall", read_stall, 0);
        chk("after_rst_we", we, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("after_rst_no_write", we, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
